uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame_if.sv | 23 ++
 rtl/uart_tx_frame.sv | 135 +++++++++++++
 tb/tb_uart_tx_frame.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - start/data handshake and line outputs of the UART frame transmitter
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 sttx_i;
    logic [DATA_BITS-1:0] d_i;
    logic                 tx_o;
    logic                 eot_o;

    modport master (
        output sttx_i,
        output d_i,
        input  tx_o,
        input  eot_o
    );

    modport slave (
        input  sttx_i,
        input  d_i,
        output tx_o,
        output eot_o
    );
endinterface

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter: start, LSB-first payload, optional parity, stop
module uart_tx_frame #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_tx_frame_if.slave   bus
);
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY != 0);
    localparam logic             PAR_INV   = (PARITY == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 eot_q, eot_d;
    logic                 bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // tx_d/eot_d are the values for the next cycle so both outputs stay registered
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        eot_d   = eot_q;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                eot_d = 1'b1;
                if (bus.sttx_i) begin
                    state_d = S_START;
                    shift_d = bus.d_i;
                    baud_d  = '0;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    tx_d    = 1'b0;
                    eot_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // parity accumulates from the latched copy as each bit leaves
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = S_PAR;
                            tx_d    = par_q ^ shift_q[0] ^ PAR_INV;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    eot_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                eot_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            eot_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            eot_q   <= eot_d;
        end
    end

    assign bus.tx_o  = tx_q;
    assign bus.eot_o = eot_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - bench for uart_tx_frame with no, even and odd parity instances
module tb_uart_tx_frame;
    localparam int B = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sttx  = 3'b000;
    logic [7:0] d     = 8'h00;
    wire  [2:0] tx_w;
    wire  [2:0] eot_w;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_frame_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_frame_if #(.DATA_BITS(8)) bus2 ();

    assign bus0.sttx_i = sttx[0];
    assign bus1.sttx_i = sttx[1];
    assign bus2.sttx_i = sttx[2];
    assign bus0.d_i    = d;
    assign bus1.d_i    = d;
    assign bus2.d_i    = d;
    assign tx_w[0]     = bus0.tx_o;
    assign tx_w[1]     = bus1.tx_o;
    assign tx_w[2]     = bus2.tx_o;
    assign eot_w[0]    = bus0.eot_o;
    assign eot_w[1]    = bus1.eot_o;
    assign eot_w[2]    = bus2.eot_o;

    uart_tx_frame #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0)) dut0 (.clk_i(clk), .rst_i(rst_n), .bus(bus0.slave));
    uart_tx_frame #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(1)) dut1 (.clk_i(clk), .rst_i(rst_n), .bus(bus1.slave));
    uart_tx_frame #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(2)) dut2 (.clk_i(clk), .rst_i(rst_n), .bus(bus2.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s u%0d tx", tag, k), 32'(tx_w[k]), 32'd1);
            check($sformatf("%s u%0d eot", tag, k), 32'(eot_w[k]), 32'd1);
        end
    endtask

    // Called at a negedge with unit u idle. hold keeps sttx high, poke re-strobes and
    // changes d mid-frame, rst_at >= 0 asserts reset in that cycle and abandons the frame.
    task automatic frame(input int u, input logic [7:0] data, input bit hold,
                         input bit poke, input int rst_at);
        logic bits[$];
        int   f;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (u != 0) bits.push_back((^data) ^ (u == 2));
        bits.push_back(1'b1);
        f = bits.size() * B;

        sttx[u] = 1'b1;
        d       = data;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c <= f; c++) begin
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("u%0d async rst tx", u), 32'(tx_w[u]), 32'd1);
                check($sformatf("u%0d async rst eot", u), 32'(eot_w[u]), 32'd1);
                sttx[u] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_idle_all("in rst");
                end
                rst_n = 1'b1;
                return;
            end
            if (c < f) begin
                check($sformatf("u%0d d=%0h c%0d tx", u, data, c), 32'(tx_w[u]), 32'(bits[c / B]));
                check($sformatf("u%0d d=%0h c%0d eot", u, data, c), 32'(eot_w[u]), 32'd0);
            end else begin
                check($sformatf("u%0d d=%0h end tx", u, data), 32'(tx_w[u]), 32'd1);
                check($sformatf("u%0d d=%0h end eot", u, data), 32'(eot_w[u]), 32'd1);
            end
            if (c == 0 && !hold) sttx[u] = 1'b0;
            if (poke && c == 10) begin
                sttx[u] = 1'b1;
                d       = ~data;
            end
            if (poke && c == 11) sttx[u] = 1'b0;
            if (c < f) @(negedge clk);
        end
        if (!hold) begin
            repeat (3) begin
                @(negedge clk);
                check($sformatf("u%0d post tx", u), 32'(tx_w[u]), 32'd1);
                check($sformatf("u%0d post eot", u), 32'(eot_w[u]), 32'd1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sttx = 3'($urandom);
            d    = 8'($urandom);
            #1;
            check_idle_all("reset");
        end
        sttx  = 3'b000;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_all("after reset");

        frame(0, 8'hA5, 1'b0, 1'b0, -1);
        frame(1, 8'h07, 1'b0, 1'b0, -1);
        frame(2, 8'h07, 1'b0, 1'b0, -1);
        frame(0, 8'($urandom), 1'b0, 1'b1, -1);
        frame(1, 8'($urandom), 1'b0, 1'b1, -1);

        frame(0, 8'h55, 1'b1, 1'b0, -1);
        frame(0, 8'h55, 1'b1, 1'b0, -1);
        frame(0, 8'h55, 1'b0, 1'b0, -1);
        frame(2, 8'h55, 1'b1, 1'b0, -1);
        frame(2, 8'h55, 1'b0, 1'b0, -1);

        frame(0, 8'($urandom), 1'b0, 1'b0, 4 * B + 1);
        frame(0, 8'h3C, 1'b0, 1'b0, -1);
        frame(1, 8'($urandom), 1'b0, 1'b0, 6 * B + 2);
        frame(1, 8'h3C, 1'b0, 1'b0, -1);

        for (int i = 0; i < 10; i++) begin
            frame(int'($urandom_range(0, 2)), 8'($urandom), 1'(i % 3 == 1) & 1'b0,
                  1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
